// File: rtl/cci_mpf_wro_event_csr_ctrl.sv
// WRO pipeline conflict event counters served over a single-outstanding CSR read port.
// Optional macro CCI_MPF_WRO_EVENT_TOTAL_EN adds an any-event cycle counter at index 6.
module cci_mpf_wro_event_csr_ctrl #(
  parameter int unsigned CTR_WIDTH = 48,
  parameter int unsigned TID_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           events,
  input  logic                 csr_rd_valid,
  input  logic [2:0]           csr_rd_idx,
  input  logic [TID_WIDTH-1:0] csr_rd_tid,
  output logic                 csr_rd_ready,
  output logic                 rsp_valid,
  output logic [TID_WIDTH-1:0] rsp_tid,
  output logic [63:0]          rsp_data,
  input  logic                 rsp_ready,
  input  logic                 ctrl_wr_valid,
  input  logic [63:0]          ctrl_wr_data
);

  typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic                 clr;
  logic [CTR_WIDTH-1:0] ctr_q [4];
  logic [CTR_WIDTH-1:0] ctr_d [4];
  logic [3:0]           sat_q, sat_d;
  logic                 freeze_q, freeze_d;
  logic [CTR_WIDTH-1:0] cyc_q, cyc_d;
  logic [63:0]          tot_val;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;
  logic [63:0]          data_q, data_d;
  logic [63:0]          sel_val;

  logic unused_wr_bits;
  assign unused_wr_bits = ^ctrl_wr_data[63:2];

  assign clr = ctrl_wr_valid & ctrl_wr_data[0];

  always_comb begin
    freeze_d = ctrl_wr_valid ? ctrl_wr_data[1] : freeze_q;
    cyc_d    = cyc_q;
    sat_d    = sat_q;
    for (int unsigned i = 0; i < 4; i++) ctr_d[i] = ctr_q[i];
    if (clr) begin
      cyc_d = '0;
      sat_d = '0;
      for (int unsigned i = 0; i < 4; i++) ctr_d[i] = '0;
    end else begin
      if (cyc_q != CTR_MAX) cyc_d = cyc_q + 1'b1;
      // Counting uses the freeze value in force before this cycle's control write.
      if (!freeze_q) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (events[i] && (ctr_q[i] != CTR_MAX)) ctr_d[i] = ctr_q[i] + 1'b1;
        end
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (ctr_d[i] == CTR_MAX) sat_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) ctr_q[i] <= '0;
      sat_q    <= '0;
      freeze_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) ctr_q[i] <= ctr_d[i];
      sat_q    <= sat_d;
      freeze_q <= freeze_d;
      cyc_q    <= cyc_d;
    end
  end

`ifdef CCI_MPF_WRO_EVENT_TOTAL_EN
  logic [CTR_WIDTH-1:0] tot_q, tot_d;

  always_comb begin
    tot_d = tot_q;
    if (clr) begin
      tot_d = '0;
    end else if (!freeze_q && (|events) && (tot_q != CTR_MAX)) begin
      tot_d = tot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tot_q <= '0;
    else          tot_q <= tot_d;
  end

  assign tot_val = 64'(tot_d);
`else
  assign tot_val = '0;
`endif

  // Snapshot reflects counter state after the CAPT cycle's update.
  always_comb begin
    sel_val = '0;
    case (idx_q)
      3'd0, 3'd1, 3'd2, 3'd3: sel_val = 64'(ctr_d[idx_q[1:0]]);
      3'd4:                   sel_val = {58'b0, sat_d, 1'b0, freeze_d};
      3'd5:                   sel_val = 64'(cyc_d);
      3'd6:                   sel_val = tot_val;
      default:                sel_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tid_d   = tid_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (csr_rd_valid) begin
          state_d = CAPT;
          idx_d   = csr_rd_idx;
          tid_d   = csr_rd_tid;
        end
      end
      CAPT: begin
        data_d  = sel_val;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tid_q   <= tid_d;
      data_q  <= data_d;
    end
  end

  assign csr_rd_ready = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_tid      = tid_q;
  assign rsp_data     = data_q;

endmodule

// File: tb/tb_cci_mpf_wro_event_csr_ctrl.sv
// Directed plus randomized checks of the WRO event CSR block against an unbounded-count reference model.
module tb_cci_mpf_wro_event_csr_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 9;
  localparam longint unsigned MAXV = (64'd1 << W) - 64'd1;

  logic          clk;
  logic          reset_n;
  logic [3:0]    events;
  logic          csr_rd_valid;
  logic [2:0]    csr_rd_idx;
  logic [TW-1:0] csr_rd_tid;
  logic          csr_rd_ready;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [63:0]   rsp_data;
  logic          rsp_ready;
  logic          ctrl_wr_valid;
  logic [63:0]   ctrl_wr_data;

  cci_mpf_wro_event_csr_ctrl #(.CTR_WIDTH(W), .TID_WIDTH(TW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .events       (events),
    .csr_rd_valid (csr_rd_valid),
    .csr_rd_idx   (csr_rd_idx),
    .csr_rd_tid   (csr_rd_tid),
    .csr_rd_ready (csr_rd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_tid      (rsp_tid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .ctrl_wr_valid(ctrl_wr_valid),
    .ctrl_wr_data (ctrl_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: true event totals, clamped only when read.
  longint unsigned cnt [4];
  longint unsigned cyc;
  longint unsigned tot;
  bit              frz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned clamp(input longint unsigned x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic logic [63:0] mval(input int idx);
    logic [63:0] v;
    v = '0;
    if (idx < 4) v = clamp(cnt[idx]);
    else if (idx == 4) begin
      for (int i = 0; i < 4; i++) if (cnt[i] >= MAXV) v[2+i] = 1'b1;
      v[0] = frz;
    end else if (idx == 5) v = clamp(cyc);
`ifdef CCI_MPF_WRO_EVENT_TOTAL_EN
    else if (idx == 6) v = clamp(tot);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    cyc = 0;
    tot = 0;
    frz = 1'b0;
  endtask

  task automatic tick();
    if (ctrl_wr_valid && ctrl_wr_data[0]) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      cyc = 0;
      tot = 0;
    end else begin
      cyc++;
      if (!frz) begin
        for (int i = 0; i < 4; i++) cnt[i] += longint'(events[i]);
        if (events != 4'b0) tot++;
      end
    end
    if (ctrl_wr_valid) frz = ctrl_wr_data[1];
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [63:0] d);
    ctrl_wr_valid = 1'b1;
    ctrl_wr_data  = d;
    tick();
    ctrl_wr_valid = 1'b0;
    ctrl_wr_data  = '0;
  endtask

  task automatic issue(input logic [2:0] idx, input logic [TW-1:0] tid, output logic [63:0] exp);
    csr_rd_valid = 1'b1;
    csr_rd_idx   = idx;
    csr_rd_tid   = tid;
    chk("rd_ready_idle", 64'(csr_rd_ready), 64'd1);
    tick();
    csr_rd_valid = 1'b0;
    chk("capt_no_rsp", 64'(rsp_valid), 64'd0);
    chk("capt_busy", 64'(csr_rd_ready), 64'd0);
    tick();
    exp = mval(int'(idx));
    chk("rsp_valid_n2", 64'(rsp_valid), 64'd1);
    chk("rsp_tid", 64'(rsp_tid), 64'(tid));
    chk("rsp_data", rsp_data, exp);
  endtask

  task automatic read(input logic [2:0] idx, input int stall, output logic [63:0] obs);
    logic [TW-1:0] tid;
    logic [63:0]   exp;
    tid = TW'($urandom);
    issue(idx, tid, exp);
    obs = rsp_data;
    for (int s = 0; s < stall; s++) begin
      csr_rd_valid = 1'b1;
      csr_rd_tid   = ~tid;
      tick();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", rsp_data, exp);
      chk("stall_tid", 64'(rsp_tid), 64'(tid));
      chk("stall_busy", 64'(csr_rd_ready), 64'd0);
    end
    csr_rd_valid = 1'b0;
    rsp_ready    = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    chk("rd_ready_back", 64'(csr_rd_ready), 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [63:0] obs;
  logic [63:0] exp;

  initial begin
    events        = '0;
    csr_rd_valid  = 1'b0;
    csr_rd_idx    = '0;
    csr_rd_tid    = '0;
    rsp_ready     = 1'b0;
    ctrl_wr_valid = 1'b0;
    ctrl_wr_data  = '0;
    reset_n       = 1'b1;
    #2;
    do_reset();

    chk("rst_rd_ready", 64'(csr_rd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);

    events = 4'b0001;
    repeat (10) tick();
    events = 4'b0000;
    read(3'd0, 0, obs);
    chk("idx0_ten", obs, 64'd10);

    events = 4'b1000;
    repeat (300) tick();
    events = 4'b0000;
    read(3'd3, 0, obs);
    chk("idx3_sat_val", obs, 64'd255);
    read(3'd4, 0, obs);
    chk("sat3_flag", 64'(obs[5]), 64'd1);

    ctrl_write(64'h2);
    events = 4'b1111;
    repeat (20) tick();
    events = 4'b0000;
    for (int i = 0; i < 6; i++) read(3'(i), 0, obs);

    ctrl_write(64'h0);
    events = 4'b0010;
    ctrl_write(64'h1);
    events = 4'b0000;
    read(3'd1, 0, obs);
    chk("clr_wins_idx1", obs, 64'd0);
    read(3'd4, 0, obs);
    chk("clr_sat_flags", obs, 64'd0);

    events = 4'b0110;
    read(3'd2, 5, obs);
    events = 4'b0000;

    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        events = 4'($urandom);
        tick();
      end
      if ($urandom_range(0, 3) == 0) ctrl_write(64'($urandom_range(0, 3)));
      events = 4'($urandom);
      read(3'($urandom_range(0, 7)), $urandom_range(0, 3), obs);
    end

    events = 4'b0000;
    repeat (3) tick();
    issue(3'd5, 9'h1a5, exp);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_in_resp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("post_rst_ready", 64'(csr_rd_ready), 64'd1);
    read(3'd0, 0, obs);
    chk("post_rst_idx0", obs, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
